fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares one sync_fifo write port among NREQ requesters. It uses the same req/gnt handshake as the existing master/slave pair. It checks FIFO full, selects a winner, and issues a registered one-cycle gnt together with fifo_write_en and the winner's data. Bounded bursts let one requester win consecutive grants without starving the others.

---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encodings,
// default sizing and the burst counter width helper.
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      ARB = 2'b00,
      GNT = 2'b01,
      REC = 2'b10
   } arb_state_t;

   localparam int DEF_NREQ      = 4;
   localparam int DEF_WIDTH     = 8;
   localparam int DEF_MAX_BURST = 4;

   // The counter must be able to hold MAX_BURST itself.
   function automatic int burst_width(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first eligible index at or above ptr,
// wrapping past NREQ-1 back to 0.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
) (
   input  logic [NREQ-1:0]         eligible,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [$clog2(NREQ)-1:0] winner,
   output logic                    valid
);

   localparam int PW = $clog2(NREQ);

   logic [2*NREQ-1:0] doubled;
   logic [NREQ-1:0]   rotated;
   int                sum;

   // Rotate so bit 0 is the ptr position; scanning downward lets the lowest offset win.
   always_comb begin
      doubled = {eligible, eligible} >> ptr;
      rotated = doubled[NREQ-1:0];
      winner  = '0;
      valid   = 1'b0;
      sum     = 0;
      for (int o = NREQ - 1; o >= 0; o--) begin
         if (rotated[o]) begin
            valid = 1'b1;
            sum   = int'(ptr) + o;
            if (sum >= NREQ) begin
               sum = sum - NREQ;
            end
            winner = PW'(sum);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port among NREQ requesters,
// with bounded bursts and a GNT/REC spacing of three cycles per word.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ      = DEF_NREQ,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   data_in,
   input  logic [NREQ-1:0]         req_mask,
   input  logic                    fifo_full,
   output logic [NREQ-1:0]         gnt,
   output logic                    fifo_write_en,
   output logic [WIDTH-1:0]        fifo_data_in,
   output logic                    busy
);

   localparam int PW = $clog2(NREQ);
   localparam int BW = burst_width(MAX_BURST);

   arb_state_t       state, state_next;
   logic [PW-1:0]    ptr, last, rr_winner, win, ptr_next;
   logic [BW-1:0]    burst_cnt;
   logic [NREQ-1:0]  eligible, gnt_next;
   logic [WIDTH-1:0] win_data;
   logic             rr_valid, cont, do_grant;

   rr_pick #(.NREQ(NREQ)) u_rr_pick (
      .eligible (eligible),
      .ptr      (ptr),
      .winner   (rr_winner),
      .valid    (rr_valid)
   );

   // A burst continues only while the previous winner stays eligible and under the limit.
   always_comb begin
      eligible = req & req_mask;
      cont     = (burst_cnt != '0) && eligible[last] && (burst_cnt < BW'(MAX_BURST));
      do_grant = (state == ARB) && !fifo_full && rr_valid;
      win      = cont ? last : rr_winner;
      ptr_next = (rr_winner == PW'(NREQ - 1)) ? '0 : rr_winner + PW'(1);
      gnt_next = '0;
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == PW'(i)) begin
            gnt_next[i] = 1'b1;
            win_data    = data_in[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_next = ARB;
      case (state)
         ARB:     state_next = do_grant ? GNT : ARB;
         GNT:     state_next = REC;
         REC:     state_next = ARB;
         default: state_next = ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ARB;
         ptr           <= '0;
         last          <= '0;
         burst_cnt     <= '0;
         gnt           <= '0;
         fifo_write_en <= 1'b0;
         fifo_data_in  <= '0;
      end else begin
         state         <= state_next;
         gnt           <= '0;
         fifo_write_en <= 1'b0;
         fifo_data_in  <= '0;
         if (do_grant) begin
            gnt           <= gnt_next;
            fifo_write_en <= 1'b1;
            fifo_data_in  <= win_data;
            if (cont) begin
               burst_cnt <= burst_cnt + BW'(1);
            end else begin
               burst_cnt <= BW'(1);
               last      <= rr_winner;
               ptr       <= ptr_next;
            end
         end else if (state == ARB) begin
            burst_cnt <= '0;
         end
      end
   end

   assign busy = (state != ARB);

endmodule
